// File: rtl/logit_diff_fp32.sv
`default_nettype none
// ============================================================================
//  Module      : logit_diff_fp32
//  Description : Multi-cycle FP32 subtractor (CLASS_DIFF = LOGIT_A - LOGIT_B)
//                with a frame-synchronous output hold for the colour stage.
//                Truncating alignment, denormal inputs flushed to zero, any
//                inf/NaN input produces the quiet NaN 0x7FC00000.
//  Revision    : 1.0 - initial release
// ============================================================================
module logit_diff_fp32 #(
    parameter int NORM_MAX = 24
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] LOGIT_A,
    input  logic [31:0] LOGIT_B,
    input  logic        start,
    input  logic        frame_start,
    output logic        ready,
    output logic        done,
    output logic [31:0] DIFF_RAW,
    output logic [31:0] CLASS_DIFF
);

    localparam int CW = $clog2(NORM_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_PACK  = 3'd4
    } state_t;

    state_t          state_q, state_d;

    logic [31:0]     a_q;        // minuend
    logic [31:0]     b_q;        // subtrahend with sign already inverted
    logic            nan_q;      // an operand had exponent 255
    logic            sign_q;     // sign of the larger-magnitude operand
    logic            sub_q;      // effective subtraction
    logic [9:0]      exp_q;      // working exponent, wide enough to see overflow
    logic [24:0]     mant_q;     // working mantissa incl. carry bit
    logic [23:0]     small_q;    // aligned smaller mantissa
    logic            zero_q;     // result collapses to +0
    logic [CW-1:0]   cnt_q;      // left shifts performed so far
    logic            done_q;
    logic [31:0]     raw_q;
    logic [31:0]     class_q;
    logic            pending_q;

    // ------------------------------------------------------------------
    // Operand decode and alignment (used during ALIGN)
    // ------------------------------------------------------------------
    logic [7:0]  ea, eb, el, es, ediff;
    logic [23:0] ma, mb, ml, ms, w_small;
    logic        a_big, sl, ss;

    // Denormals flush to zero by giving them an all-zero mantissa.
    assign ea    = a_q[30:23];
    assign eb    = b_q[30:23];
    assign ma    = (ea != 8'd0) ? {1'b1, a_q[22:0]} : 24'd0;
    assign mb    = (eb != 8'd0) ? {1'b1, b_q[22:0]} : 24'd0;
    assign a_big = ({ea, ma} >= {eb, mb});
    assign el    = a_big ? ea : eb;
    assign es    = a_big ? eb : ea;
    assign ml    = a_big ? ma : mb;
    assign ms    = a_big ? mb : ma;
    assign sl    = a_big ? a_q[31] : b_q[31];
    assign ss    = a_big ? b_q[31] : a_q[31];
    assign ediff = el - es;
    assign w_small = (ediff >= 8'd25) ? 24'd0 : (ms >> ediff);

    // ------------------------------------------------------------------
    // Normalisation decisions (used during NORM)
    // ------------------------------------------------------------------
    logic w_underflow, w_norm_exit, w_left;

    // A further left shift would drive the exponent to 0 or exceed the budget.
    assign w_underflow = (exp_q <= 10'd1) || (cnt_q == CW'(NORM_MAX));
    assign w_left      = !nan_q && !mant_q[24] && (mant_q != 25'd0) && !mant_q[23];
    assign w_norm_exit = !w_left || w_underflow;

    // ------------------------------------------------------------------
    // Result word assembly (used during PACK)
    // ------------------------------------------------------------------
    logic [31:0] w_word;

    // Select NaN, zero, infinity or the normal packed word.
    always_comb begin
        w_word = {sign_q, exp_q[7:0], mant_q[22:0]};
        if (nan_q)
            w_word = 32'h7FC0_0000;
        else if (zero_q)
            w_word = 32'h0000_0000;
        else if (exp_q >= 10'd255)
            w_word = {sign_q, 8'hFF, 23'd0};
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state sequencing; NORM repeats until the mantissa is normalised.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start)
                    state_d = S_ALIGN;
            end
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  if (w_norm_exit) state_d = S_PACK;
            S_PACK:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Arithmetic datapath, one step per state.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            nan_q   <= 1'b0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= 10'd0;
            mant_q  <= 25'd0;
            small_q <= 24'd0;
            zero_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            raw_q   <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= LOGIT_A;
                        b_q   <= {~LOGIT_B[31], LOGIT_B[30:0]};
                        nan_q <= (LOGIT_A[30:23] == 8'hFF) || (LOGIT_B[30:23] == 8'hFF);
                    end
                end
                S_ALIGN: begin
                    sign_q  <= sl;
                    sub_q   <= sl ^ ss;
                    exp_q   <= {2'b00, el};
                    mant_q  <= {1'b0, ml};
                    small_q <= w_small;
                    zero_q  <= 1'b0;
                    cnt_q   <= '0;
                end
                S_ADD: begin
                    // Larger magnitude is always the minuend, so no borrow out.
                    if (sub_q)
                        mant_q <= {1'b0, mant_q[23:0]} - {1'b0, small_q};
                    else
                        mant_q <= {1'b0, mant_q[23:0]} + {1'b0, small_q};
                end
                S_NORM: begin
                    if (!nan_q) begin
                        if (mant_q[24]) begin
                            mant_q <= mant_q >> 1;
                            exp_q  <= exp_q + 10'd1;
                        end else if (mant_q == 25'd0) begin
                            zero_q <= 1'b1;
                        end else if (!mant_q[23]) begin
                            if (w_underflow) begin
                                zero_q <= 1'b1;
                            end else begin
                                mant_q <= mant_q << 1;
                                exp_q  <= exp_q - 10'd1;
                                cnt_q  <= cnt_q + CW'(1);
                            end
                        end
                    end
                end
                S_PACK: begin
                    raw_q  <= w_word;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Frame hold: publish the latest result only on a vertical-blank pulse.
    // A new result sets pending on the same edge that raises done, so a
    // frame_start coinciding with done copies the new word straight through.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pending_q <= 1'b0;
            class_q   <= 32'd0;
        end else begin
            if (frame_start && pending_q)
                class_q <= raw_q;
            if (state_q == S_PACK)
                pending_q <= 1'b1;
            else if (frame_start && pending_q)
                pending_q <= 1'b0;
        end
    end

    assign done       = done_q;
    assign DIFF_RAW   = raw_q;
    assign CLASS_DIFF = class_q;

endmodule
`default_nettype wire

// File: tb/tb_logit_diff_fp32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logit_diff_fp32
//  Description : Scoreboard bench for logit_diff_fp32 with a value-level
//                reference model of truncating FP32 subtraction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logit_diff_fp32;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] LOGIT_A = 32'd0;
    logic [31:0] LOGIT_B = 32'd0;
    logic        start = 1'b0;
    logic        fs_auto = 1'b0;
    logic        fs_man = 1'b0;
    logic        fs_en = 1'b0;
    logic        frame_start;
    logic        ready, done;
    logic [31:0] DIFF_RAW, CLASS_DIFF;

    assign frame_start = fs_auto | fs_man;

    logit_diff_fp32 #(.NORM_MAX(24)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .LOGIT_A     (LOGIT_A),
        .LOGIT_B     (LOGIT_B),
        .start       (start),
        .frame_start (frame_start),
        .ready       (ready),
        .done        (done),
        .DIFF_RAW    (DIFF_RAW),
        .CLASS_DIFF  (CLASS_DIFF)
    );

    always #10 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] word;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] raw_m = 32'd0;
    logic [31:0] cls_m = 32'd0;
    bit          pend_m = 1'b0;

    // Value-level model: align by exponent difference with truncation,
    // add signed magnitudes, renormalise; k = number of left shifts.
    function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] w, output int k);
        int     ea, eb, ma, mb, el, es, ml, ms, d, m, e;
        bit     sa, sb, sl, ss;
        longint va, vb;
        logic [7:0] e8;
        k  = 0;
        sa = a[31];
        sb = ~b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if (ea == 255 || eb == 255) begin
            w = 32'h7FC0_0000;
            return;
        end
        ma = (ea == 0) ? 0 : (int'(a[22:0]) + (1 << 23));
        mb = (eb == 0) ? 0 : (int'(b[22:0]) + (1 << 23));
        va = longint'(ea) * 64'd16777216 + longint'(ma);
        vb = longint'(eb) * 64'd16777216 + longint'(mb);
        if (va >= vb) begin el = ea; ml = ma; sl = sa; es = eb; ms = mb; ss = sb; end
        else          begin el = eb; ml = mb; sl = sb; es = ea; ms = ma; ss = sa; end
        d = el - es;
        if (d >= 25) ms = 0; else ms = ms >> d;
        m = (sl == ss) ? (ml + ms) : (ml - ms);
        e = el;
        if (m >= (1 << 24)) begin
            m = m >> 1;
            e = e + 1;
        end else if (m == 0) begin
            w = 32'd0;
            return;
        end else begin
            while (m < (1 << 23)) begin
                if (e <= 1 || k == 24) begin
                    w = 32'd0;
                    return;
                end
                m = m << 1;
                e = e - 1;
                k = k + 1;
            end
        end
        e8 = e[7:0];
        if (e >= 255) w = {sl, 8'hFF, 23'd0};
        else          w = {sl, e8, m[22:0]};
    endfunction

    // Monitor: pop expectations on done, track the frame-held output.
    always @(negedge Clk) begin
        exp_t ex;
        if (!Reset_n) begin
            sb_q.delete();
            raw_m  = 32'd0;
            cls_m  = 32'd0;
            pend_m = 1'b0;
            checks++;
            if (done !== 1'b0 || ready !== 1'b1 || DIFF_RAW !== 32'd0 || CLASS_DIFF !== 32'd0) begin
                errors++;
                $display("FAIL reset_state: done=%b ready=%b raw=%h class=%h, want 0 1 0 0",
                         done, ready, DIFF_RAW, CLASS_DIFF);
            end
        end else begin
            if (done === 1'b1) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done: raw=%h at cycle %0d, no operation pending", DIFF_RAW, cyc);
                end else begin
                    ex = sb_q.pop_front();
                    if (DIFF_RAW !== ex.word) begin
                        errors++;
                        $display("FAIL diff_raw: got %h want %h", DIFF_RAW, ex.word);
                    end
                    checks++;
                    if (cyc != ex.due) begin
                        errors++;
                        $display("FAIL latency: done at cycle %0d want %0d", cyc, ex.due);
                    end
                    raw_m  = ex.word;
                    pend_m = 1'b1;
                end
            end else if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
                ex = sb_q.pop_front();
                checks++;
                errors++;
                $display("FAIL done_timeout: no done by cycle %0d (word %h)", ex.due, ex.word);
            end
            checks++;
            if (CLASS_DIFF !== cls_m) begin
                errors++;
                $display("FAIL class_diff: got %h want %h at cycle %0d", CLASS_DIFF, cls_m, cyc);
            end
            if (frame_start === 1'b1 && pend_m) begin
                cls_m  = raw_m;
                pend_m = 1'b0;
            end
        end
    end

    // Background vertical-blank pulses, changed just after the rising edge.
    always @(posedge Clk) begin
        #1 fs_auto = fs_en && ($urandom_range(0, 15) == 0);
    end

    // Issue one operation when ready; returns the expected done cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, output int due);
        logic [31:0] w;
        int k, t;
        t = 0;
        @(negedge Clk);
        while (ready !== 1'b1 && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b want 1", ready);
            due = -1;
            return;
        end
        ref_sub(a, b, w, k);
        due     = cyc + 1 + 4 + k;
        LOGIT_A = a;
        LOGIT_B = b;
        start   = 1'b1;
        sb_q.push_back('{w, due});
        @(negedge Clk);
        start   = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(negedge Clk);
            t++;
        end
        repeat (2) @(negedge Clk);
    endtask

    task automatic pulse_frame();
        @(posedge Clk);
        #1 fs_man = 1'b1;
        @(posedge Clk);
        #1 fs_man = 1'b0;
    endtask

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        int sel;
        v   = $urandom;
        sel = $urandom_range(0, 39);
        if (sel == 0)      v[30:23] = 8'd0;
        else if (sel == 1) v[30:23] = 8'hFF;
        else               v[30:23] = 8'($urandom_range(100, 150));
        return v;
    endfunction

    initial begin
        int due;
        logic [31:0] a, b;
        repeat (3) @(negedge Clk);
        #5 Reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        // 3 - 1, then shown only at the next frame boundary
        do_op(32'h4040_0000, 32'h3F80_0000, due);
        wait_idle();
        repeat (4) @(negedge Clk);
        pulse_frame();
        repeat (2) @(negedge Clk);

        // 1 - 0.75 needs two left shifts
        do_op(32'h3F80_0000, 32'h3F40_0000, due);
        wait_idle();
        do_op(32'h3FA0_0000, 32'h3FA0_0000, due);     // exact cancellation
        do_op(32'hBF80_0000, 32'h3F80_0000, due);     // -1 - 1
        do_op(32'h7F7F_FFFF, 32'hFF7F_FFFF, due);     // overflow to +inf
        wait_idle();

        // inf operand, with start held while busy
        do_op(32'h7F80_0000, 32'h3F80_0000, due);
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL busy_ready: ready=%b want 0", ready);
        end
        LOGIT_A = 32'h4000_0000;
        LOGIT_B = 32'h3F80_0000;
        start   = 1'b1;
        repeat (2) @(negedge Clk);
        start   = 1'b0;
        wait_idle();

        // done coincident with frame_start updates the held output at once
        do_op(32'h4100_0000, 32'h3F80_0000, due);
        while (cyc < due - 1) @(posedge Clk);
        @(posedge Clk);
        #1 fs_man = 1'b1;
        @(posedge Clk);
        #1 fs_man = 1'b0;
        wait_idle();

        // reset during NORM aborts the operation
        do_op(32'h3F80_0000, 32'h3F40_0000, due);
        repeat (3) @(negedge Clk);
        #5 Reset_n = 1'b0;
        repeat (2) @(negedge Clk);
        #5 Reset_n = 1'b1;
        do_op(32'h4040_0000, 32'h3F80_0000, due);
        wait_idle();
        pulse_frame();
        repeat (2) @(negedge Clk);

        // randomized operations with free-running frame pulses
        fs_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = rand_fp();
            b = ($urandom_range(0, 9) == 0) ? a : rand_fp();
            if ($urandom_range(0, 9) == 0) b[30:23] = a[30:23];
            do_op(a, b, due);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge Clk);
        end
        wait_idle();
        fs_en = 1'b0;
        repeat (4) @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
